// File: rtl/counter_seq.sv
// Prescaled sequencer that strobes an external next-state stage, captures its
// result in a count register and offers every new RUN count on a one-entry stream.
module counter_seq (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_start,
    input  logic       io_stop,
    input  logic       io_clear,
    input  logic [3:0] io_div,
    input  logic [3:0] io_next,
    output logic       io_step,
    output logic       io_zero,
    output logic [3:0] io_cur,
    output logic       io_wrap,
    output logic       io_deq_valid,
    input  logic       io_deq_ready,
    output logic [3:0] io_deq_bits,
    output logic       io_ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] pre_r;
    logic [3:0] pre_nxt_s;
    logic [3:0] count_r;
    logic       wrap_r;
    logic       deq_valid_r;
    logic [3:0] deq_bits_r;
    logic       ovf_r;
    logic       pre_hit_s;
    logic       run_step_s;
    logic       step_s;
    logic       transfer_s;

    // Prescale comparison is >= so that lowering io_div mid-period ends it at once.
    assign pre_hit_s  = (pre_r >= io_div);
    assign run_step_s = (state_r == RUN) && pre_hit_s;
    assign step_s     = run_step_s || (state_r == CLEAR);
    assign transfer_s = deq_valid_r && io_deq_ready;

    // Next-state selection; clear outranks stop, which outranks start.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (io_clear) begin
                    state_nxt_s = CLEAR;
                end else if (io_start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (io_clear) begin
                    state_nxt_s = CLEAR;
                end else if (io_stop) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            CLEAR:   state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Prescaler only runs while staying in RUN, so every RUN entry starts a fresh period.
    always_comb begin
        pre_nxt_s = 4'd0;
        if ((state_r == RUN) && (state_nxt_s == RUN)) begin
            if (pre_hit_s) begin
                pre_nxt_s = 4'd0;
            end else begin
                pre_nxt_s = pre_r + 4'd1;
            end
        end else begin
            pre_nxt_s = 4'd0;
        end
    end

    // FSM and prescaler registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            pre_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            pre_r   <= pre_nxt_s;
        end
    end

    // Count register follows the next-state stage on every strobe; wrap flags a RUN 15->0.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= 4'd0;
            wrap_r  <= 1'b0;
        end else begin
            if (step_s) begin
                count_r <= io_next;
            end else begin
                count_r <= count_r;
            end
            wrap_r <= run_step_s && (count_r == 4'd15) && (io_next == 4'd0);
        end
    end

    // One-entry sample buffer: newest RUN value always wins, a lost sample sets ovf.
    always_ff @(posedge clock) begin
        if (reset) begin
            deq_valid_r <= 1'b0;
            deq_bits_r  <= 4'd0;
            ovf_r       <= 1'b0;
        end else begin
            if (run_step_s) begin
                deq_valid_r <= 1'b1;
                deq_bits_r  <= io_next;
            end else if (transfer_s) begin
                deq_valid_r <= 1'b0;
                deq_bits_r  <= deq_bits_r;
            end else begin
                deq_valid_r <= deq_valid_r;
                deq_bits_r  <= deq_bits_r;
            end

            if ((state_nxt_s == CLEAR) && (state_r != CLEAR)) begin
                ovf_r <= 1'b0;
            end else if (run_step_s && deq_valid_r && !io_deq_ready) begin
                ovf_r <= 1'b1;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    assign io_step      = step_s;
    assign io_zero      = (state_r == CLEAR);
    assign io_cur       = count_r;
    assign io_wrap      = wrap_r;
    assign io_deq_valid = deq_valid_r;
    assign io_deq_bits  = deq_bits_r;
    assign io_ovf       = ovf_r;

endmodule

// File: tb/tb_counter_seq.sv
// Bench for counter_seq: a vector table for the basic sequences plus hand-built
// sequences for wrap, overflow, input priority and reset override.
module tb_counter_seq;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       io_start = 1'b0;
    logic       io_stop = 1'b0;
    logic       io_clear = 1'b0;
    logic [3:0] io_div = 4'd0;
    logic [3:0] io_next;
    logic       io_step;
    logic       io_zero;
    logic [3:0] io_cur;
    logic       io_wrap;
    logic       io_deq_valid;
    logic       io_deq_ready = 1'b1;
    logic [3:0] io_deq_bits;
    logic       io_ovf;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic       rst;
        logic       start;
        logic       stop;
        logic       clr;
        logic [3:0] div;
        logic       rdy;
        logic       chk;
        logic       step;
        logic       zero;
        logic [3:0] cur;
        logic       wrap;
        logic       vld;
        logic [3:0] bits;
        logic       ovf;
    } vec_t;

    vec_t vec_tab [27];
    vec_t exp_q [$];

    counter_seq dut (
        .clock        (clock),
        .reset        (reset),
        .io_start     (io_start),
        .io_stop      (io_stop),
        .io_clear     (io_clear),
        .io_div       (io_div),
        .io_next      (io_next),
        .io_step      (io_step),
        .io_zero      (io_zero),
        .io_cur       (io_cur),
        .io_wrap      (io_wrap),
        .io_deq_valid (io_deq_valid),
        .io_deq_ready (io_deq_ready),
        .io_deq_bits  (io_deq_bits),
        .io_ovf       (io_ovf)
    );

    always #5 clock = ~clock;

    // Downstream next-state stage: increments on a step, zeroes on a clear strobe.
    always_comb begin
        io_next = io_cur;
        if (io_zero) begin
            io_next = 4'd0;
        end else if (io_step) begin
            io_next = io_cur + 4'd1;
        end else begin
            io_next = io_cur;
        end
    end

    function automatic vec_t mk(input logic rst, input logic start, input logic stop,
                                input logic clr, input logic [3:0] div, input logic rdy,
                                input logic step, input logic zero, input logic [3:0] cur,
                                input logic wrap, input logic vld, input logic [3:0] bits,
                                input logic ovf);
        vec_t v;
        v = '{rst, start, stop, clr, div, rdy, 1'b1, step, zero, cur, wrap, vld, bits, ovf};
        return v;
    endfunction

    task automatic cmp(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    int cyc_idx = 0;

    // One cycle: drive after the rising edge, queue the expectation, check at the falling edge.
    task automatic run_cycle(input vec_t v);
        vec_t e;
        @(posedge clock);
        #1;
        reset        = v.rst;
        io_start     = v.start;
        io_stop      = v.stop;
        io_clear     = v.clr;
        io_div       = v.div;
        io_deq_ready = v.rdy;
        exp_q.push_back(v);
        @(negedge clock);
        e = exp_q.pop_front();
        if (e.chk) begin
            cmp("step",      cyc_idx, {3'd0, io_step},      {3'd0, e.step});
            cmp("zero",      cyc_idx, {3'd0, io_zero},      {3'd0, e.zero});
            cmp("cur",       cyc_idx, io_cur,               e.cur);
            cmp("wrap",      cyc_idx, {3'd0, io_wrap},      {3'd0, e.wrap});
            cmp("deq_valid", cyc_idx, {3'd0, io_deq_valid}, {3'd0, e.vld});
            cmp("deq_bits",  cyc_idx, io_deq_bits,          e.bits);
            cmp("ovf",       cyc_idx, {3'd0, io_ovf},       {3'd0, e.ovf});
        end
        cyc_idx++;
    endtask

    initial begin
        //                 rst  st  sp  cl  div  rdy   step zero cur wrap vld bits ovf
        vec_tab[0]  = mk(1'b1,1'b0,1'b0,1'b0,4'd0,1'b1, 1'b0,1'b0,4'd0,1'b0,1'b0,4'd0,1'b0);
        vec_tab[0].chk = 1'b0;
        vec_tab[1]  = mk(1'b0,1'b1,1'b0,1'b0,4'd0,1'b1, 1'b0,1'b0,4'd0,1'b0,1'b0,4'd0,1'b0);
        vec_tab[2]  = mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b1, 1'b1,1'b0,4'd0,1'b0,1'b0,4'd0,1'b0);
        vec_tab[3]  = mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b1, 1'b1,1'b0,4'd1,1'b0,1'b1,4'd1,1'b0);
        vec_tab[4]  = mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b1, 1'b1,1'b0,4'd2,1'b0,1'b1,4'd2,1'b0);
        vec_tab[5]  = mk(1'b0,1'b0,1'b1,1'b0,4'd0,1'b1, 1'b1,1'b0,4'd3,1'b0,1'b1,4'd3,1'b0);
        vec_tab[6]  = mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b1, 1'b0,1'b0,4'd4,1'b0,1'b1,4'd4,1'b0);
        vec_tab[7]  = mk(1'b1,1'b0,1'b0,1'b0,4'd0,1'b1, 1'b0,1'b0,4'd4,1'b0,1'b0,4'd4,1'b0);
        vec_tab[8]  = mk(1'b0,1'b1,1'b0,1'b0,4'd3,1'b1, 1'b0,1'b0,4'd0,1'b0,1'b0,4'd0,1'b0);
        vec_tab[9]  = mk(1'b0,1'b0,1'b0,1'b0,4'd3,1'b1, 1'b0,1'b0,4'd0,1'b0,1'b0,4'd0,1'b0);
        vec_tab[10] = mk(1'b0,1'b0,1'b0,1'b0,4'd3,1'b1, 1'b0,1'b0,4'd0,1'b0,1'b0,4'd0,1'b0);
        vec_tab[11] = mk(1'b0,1'b0,1'b0,1'b0,4'd3,1'b1, 1'b0,1'b0,4'd0,1'b0,1'b0,4'd0,1'b0);
        vec_tab[12] = mk(1'b0,1'b0,1'b0,1'b0,4'd3,1'b1, 1'b1,1'b0,4'd0,1'b0,1'b0,4'd0,1'b0);
        vec_tab[13] = mk(1'b0,1'b0,1'b0,1'b0,4'd3,1'b1, 1'b0,1'b0,4'd1,1'b0,1'b1,4'd1,1'b0);
        vec_tab[14] = mk(1'b0,1'b0,1'b0,1'b0,4'd3,1'b1, 1'b0,1'b0,4'd1,1'b0,1'b0,4'd1,1'b0);
        vec_tab[15] = mk(1'b0,1'b0,1'b0,1'b0,4'd3,1'b1, 1'b0,1'b0,4'd1,1'b0,1'b0,4'd1,1'b0);
        vec_tab[16] = mk(1'b0,1'b0,1'b0,1'b0,4'd3,1'b1, 1'b1,1'b0,4'd1,1'b0,1'b0,4'd1,1'b0);
        vec_tab[17] = mk(1'b0,1'b0,1'b0,1'b0,4'd3,1'b1, 1'b0,1'b0,4'd2,1'b0,1'b1,4'd2,1'b0);
        vec_tab[18] = mk(1'b0,1'b0,1'b0,1'b0,4'd3,1'b1, 1'b0,1'b0,4'd2,1'b0,1'b0,4'd2,1'b0);
        vec_tab[19] = mk(1'b0,1'b0,1'b0,1'b0,4'd3,1'b1, 1'b0,1'b0,4'd2,1'b0,1'b0,4'd2,1'b0);
        vec_tab[20] = mk(1'b0,1'b0,1'b0,1'b0,4'd3,1'b1, 1'b1,1'b0,4'd2,1'b0,1'b0,4'd2,1'b0);
        vec_tab[21] = mk(1'b0,1'b0,1'b0,1'b0,4'd3,1'b1, 1'b0,1'b0,4'd3,1'b0,1'b1,4'd3,1'b0);
        vec_tab[22] = mk(1'b0,1'b0,1'b0,1'b0,4'd1,1'b1, 1'b1,1'b0,4'd3,1'b0,1'b0,4'd3,1'b0);
        vec_tab[23] = mk(1'b0,1'b0,1'b0,1'b0,4'd1,1'b1, 1'b0,1'b0,4'd4,1'b0,1'b1,4'd4,1'b0);
        vec_tab[24] = mk(1'b0,1'b0,1'b0,1'b0,4'd1,1'b1, 1'b1,1'b0,4'd4,1'b0,1'b0,4'd4,1'b0);
        vec_tab[25] = mk(1'b0,1'b0,1'b1,1'b0,4'd1,1'b1, 1'b0,1'b0,4'd5,1'b0,1'b1,4'd5,1'b0);
        vec_tab[26] = mk(1'b0,1'b0,1'b0,1'b0,4'd1,1'b1, 1'b0,1'b0,4'd5,1'b0,1'b0,4'd5,1'b0);

        for (int i = 0; i < 27; i++) begin
            run_cycle(vec_tab[i]);
        end

        // Count from 5 up to 15 with div=0, then observe the single wrap pulse.
        run_cycle(mk(1'b0,1'b1,1'b0,1'b0,4'd0,1'b1, 1'b0,1'b0,4'd5,1'b0,1'b0,4'd5,1'b0));
        for (int j = 0; j <= 10; j++) begin
            logic [3:0] c;
            c = 4'd5 + 4'(j);
            run_cycle(mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b1, 1'b1,1'b0,c,1'b0,(j != 0),c,1'b0));
        end
        run_cycle(mk(1'b0,1'b0,1'b1,1'b0,4'd0,1'b1, 1'b1,1'b0,4'd0,1'b1,1'b1,4'd0,1'b0));
        run_cycle(mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b1, 1'b0,1'b0,4'd1,1'b0,1'b1,4'd1,1'b0));

        // Overwrites with ready low set ovf; clearing from IDLE drops it and zeroes the count.
        run_cycle(mk(1'b0,1'b1,1'b0,1'b0,4'd0,1'b0, 1'b0,1'b0,4'd1,1'b0,1'b0,4'd1,1'b0));
        run_cycle(mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 1'b1,1'b0,4'd1,1'b0,1'b0,4'd1,1'b0));
        run_cycle(mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 1'b1,1'b0,4'd2,1'b0,1'b1,4'd2,1'b0));
        run_cycle(mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 1'b1,1'b0,4'd3,1'b0,1'b1,4'd3,1'b1));
        run_cycle(mk(1'b0,1'b0,1'b1,1'b0,4'd0,1'b0, 1'b1,1'b0,4'd4,1'b0,1'b1,4'd4,1'b1));
        run_cycle(mk(1'b0,1'b0,1'b0,1'b1,4'd0,1'b0, 1'b0,1'b0,4'd5,1'b0,1'b1,4'd5,1'b1));
        run_cycle(mk(1'b0,1'b1,1'b0,1'b0,4'd0,1'b0, 1'b1,1'b1,4'd5,1'b0,1'b1,4'd5,1'b0));
        run_cycle(mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b1, 1'b0,1'b0,4'd0,1'b0,1'b1,4'd5,1'b0));

        // Priority: stop+start in IDLE enters RUN; clear+stop+start in RUN enters CLEAR.
        run_cycle(mk(1'b0,1'b1,1'b1,1'b0,4'd0,1'b1, 1'b0,1'b0,4'd0,1'b0,1'b0,4'd5,1'b0));
        run_cycle(mk(1'b0,1'b1,1'b1,1'b1,4'd0,1'b1, 1'b1,1'b0,4'd0,1'b0,1'b0,4'd5,1'b0));
        run_cycle(mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b1, 1'b1,1'b1,4'd1,1'b0,1'b1,4'd1,1'b0));
        run_cycle(mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b1, 1'b0,1'b0,4'd0,1'b0,1'b0,4'd1,1'b0));

        // Reset overrides a live RUN with a pending sample, and again while in CLEAR.
        run_cycle(mk(1'b0,1'b1,1'b0,1'b0,4'd0,1'b0, 1'b0,1'b0,4'd0,1'b0,1'b0,4'd1,1'b0));
        run_cycle(mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 1'b1,1'b0,4'd0,1'b0,1'b0,4'd1,1'b0));
        run_cycle(mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 1'b1,1'b0,4'd1,1'b0,1'b1,4'd1,1'b0));
        run_cycle(mk(1'b1,1'b1,1'b0,1'b1,4'd0,1'b0, 1'b1,1'b0,4'd2,1'b0,1'b1,4'd2,1'b1));
        run_cycle(mk(1'b0,1'b0,1'b0,1'b1,4'd0,1'b1, 1'b0,1'b0,4'd0,1'b0,1'b0,4'd0,1'b0));
        run_cycle(mk(1'b1,1'b1,1'b0,1'b0,4'd0,1'b1, 1'b1,1'b1,4'd0,1'b0,1'b0,4'd0,1'b0));
        run_cycle(mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b1, 1'b0,1'b0,4'd0,1'b0,1'b0,4'd0,1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
